// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: PC input, program-memory read port and the
// valid/ready instruction path toward the decoder.
interface instr_fetch_if #(
    parameter int W  = 8,
    parameter int IW = 16
);
    logic [W-1:0]  PC_count;
    logic          skok_pc;
    logic          ID_rst;
    logic          pc_ink;
    logic          mem_rd;
    logic [W-1:0]  mem_addr;
    logic [IW-1:0] mem_data;
    logic [IW-1:0] IF_instr;
    logic [W-1:0]  IF_pc;
    logic          IF_valid;
    logic          ID_ready;

    modport master (
        input  PC_count, skok_pc, ID_rst, mem_data, ID_ready,
        output pc_ink, mem_rd, mem_addr, IF_instr, IF_pc, IF_valid
    );

    modport slave (
        output PC_count, skok_pc, ID_rst, mem_data, ID_ready,
        input  pc_ink, mem_rd, mem_addr, IF_instr, IF_pc, IF_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one program-memory read per accepted PC,
// tags returned words with their address and queues them for the decoder.
module instr_fetch #(
    parameter int W     = 8,
    parameter int IW    = 16,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_if.master      bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic           w_flush;
    logic           w_pop;
    logic           w_push;
    logic           w_issue;
    logic           w_room;
    logic           r_inflight;
    logic [W-1:0]   r_issueAddr;
    logic [W-1:0]   r_fifoPc    [DEPTH];
    logic [IW-1:0]  r_fifoInstr [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [OW-1:0]  w_used;
    logic [OW-1:0]  w_limit;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_flush  = bus.skok_pc | bus.ID_rst;
    assign w_pop    = bus.IF_valid & bus.ID_ready;
    // A word returning during a flush cycle belongs to the abandoned path.
    assign w_push   = r_inflight & ~w_flush;

    // Entries popped this cycle free their slot for a read issued now.
    assign w_used   = OW'(r_count) + OW'(r_inflight);
    assign w_limit  = OW'(DEPTH) + OW'(w_pop);
    assign w_room   = (w_used < w_limit);

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        if (w_flush) begin
            w_nextState = FLUSH;
        end else begin
            unique case (r_state)
                IDLE:  w_nextState = RUN;
                RUN: begin
                    w_nextState = RUN;
                    w_issue     = w_room & ~rst;
                end
                FLUSH: w_nextState = RUN;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_issueAddr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issueAddr <= bus.PC_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifoPc[i]    <= '0;
                r_fifoInstr[i] <= '0;
            end
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifoPc[r_tail]    <= r_issueAddr;
                r_fifoInstr[r_tail] <= bus.mem_data;
                r_tail              <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && !w_flush && (r_count == CW'(DEPTH))));
        end
    end

    assign bus.mem_rd   = w_issue;
    assign bus.pc_ink   = w_issue;
    assign bus.mem_addr = bus.PC_count;
    assign bus.IF_valid = (r_count != '0);
    assign bus.IF_instr = r_fifoInstr[r_head];
    assign bus.IF_pc    = r_fifoPc[r_head];
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: PC and program-memory models around the
// DUT, directed scenarios plus a randomized run against a program-order model.
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tbPc;
    logic [7:0] jumpTarget = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.W(8), .IW(16)) bus();

    instr_fetch #(.W(8), .IW(16), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.PC_count = tbPc;

    // Program counter: local reset beats jump, jump beats increment.
    always @(posedge clk) begin
        if (rst || bus.ID_rst)  tbPc <= 8'h00;
        else if (bus.skok_pc)   tbPc <= jumpTarget;
        else if (bus.pc_ink)    tbPc <= tbPc + 8'h01;
    end

    // Synchronous program memory holding mem[a] = {a, ~a}.
    always @(posedge clk) begin
        bus.mem_data <= bus.mem_rd ? {bus.mem_addr, ~bus.mem_addr} : 16'hDEAD;
    end

    task automatic applyStimulus(input logic r, input logic ready, input logic skok,
                                 input logic idrst, input logic [7:0] tgt);
        @(negedge clk);
        rst          = r;
        bus.ID_ready = ready;
        bus.skok_pc  = skok;
        bus.ID_rst   = idrst;
        jumpTarget   = tgt;
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            checks++;
            if ({bus.IF_valid, bus.mem_rd, bus.pc_ink, bus.IF_pc, bus.IF_instr} !== 27'd0) begin
                errors++;
                $display("[TB] FAIL reset_values c=%0d: got v=%b rd=%b ink=%b pc=%h instr=%h expected all zero",
                         c, bus.IF_valid, bus.mem_rd, bus.pc_ink, bus.IF_pc, bus.IF_instr);
            end
        end
    endtask

    task automatic test_stream();
        logic [7:0] e;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            checks++;
            if (c == 0) begin
                if (bus.mem_rd !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stream_idle_rd: got %b expected 0", bus.mem_rd);
                end
            end else begin
                e = 8'(c - 1);
                if ({bus.mem_rd, bus.pc_ink, bus.mem_addr} !== {2'b11, e}) begin
                    errors++;
                    $display("[TB] FAIL stream_issue c=%0d: got rd=%b ink=%b addr=%h expected 1/1/%h",
                             c, bus.mem_rd, bus.pc_ink, bus.mem_addr, e);
                end
            end
            checks++;
            if (c < 3) begin
                if (bus.IF_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stream_latency c=%0d: got valid=%b expected 0", c, bus.IF_valid);
                end
            end else begin
                e = 8'(c - 3);
                if ({bus.IF_valid, bus.IF_pc, bus.IF_instr} !== {1'b1, e, e, ~e}) begin
                    errors++;
                    $display("[TB] FAIL stream_out c=%0d: got %b/%h/%h expected 1/%h/%h",
                             c, bus.IF_valid, bus.IF_pc, bus.IF_instr, e, {e, ~e});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int         issues = 0;
        logic [7:0] e;
        doReset();
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            if (bus.pc_ink === 1'b1) issues++;
            if (c >= 3) begin
                checks++;
                if ({bus.IF_valid, bus.IF_pc, bus.mem_rd, bus.pc_ink} !== {1'b1, 8'h00, 2'b00}) begin
                    errors++;
                    $display("[TB] FAIL stall_hold c=%0d: got v=%b pc=%h rd=%b ink=%b expected 1/00/0/0",
                             c, bus.IF_valid, bus.IF_pc, bus.mem_rd, bus.pc_ink);
                end
            end
        end
        checks++;
        if (issues != 2) begin
            errors++;
            $display("[TB] FAIL stall_issue_count: got %0d expected 2", issues);
        end
        for (int d = 0; d < 6; d++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            e = 8'(d);
            checks++;
            if ({bus.IF_valid, bus.IF_pc, bus.IF_instr} !== {1'b1, e, e, ~e}) begin
                errors++;
                $display("[TB] FAIL drain d=%0d: got %b/%h/%h expected 1/%h/%h",
                         d, bus.IF_valid, bus.IF_pc, bus.IF_instr, e, {e, ~e});
            end
        end
    endtask

    task automatic test_jump();
        doReset();
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 1'b1, (c == 6), 1'b0, 8'hAA);
            if (c == 6) begin
                checks++;
                if ({bus.mem_addr, bus.mem_rd, bus.IF_valid, bus.IF_pc} !== {8'h05, 1'b0, 1'b1, 8'h03}) begin
                    errors++;
                    $display("[TB] FAIL jump_cycle: got addr=%h rd=%b v=%b pc=%h expected 05/0/1/03",
                             bus.mem_addr, bus.mem_rd, bus.IF_valid, bus.IF_pc);
                end
            end else if (c == 7 || c == 9) begin
                checks++;
                if (bus.IF_valid !== 1'b0 || (c == 7 && bus.mem_rd !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL jump_flushed c=%0d: got v=%b rd=%b expected 0/0", c, bus.IF_valid, bus.mem_rd);
                end
            end else if (c == 8) begin
                checks++;
                if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'hAA}) begin
                    errors++;
                    $display("[TB] FAIL jump_issue: got rd=%b addr=%h expected 1/AA", bus.mem_rd, bus.mem_addr);
                end
            end else if (c >= 10) begin
                checks++;
                if ({bus.IF_valid, bus.IF_pc, bus.IF_instr} !== ((c == 10) ? 25'h1_AA_AA55 : 25'h1_AB_AB54)) begin
                    errors++;
                    $display("[TB] FAIL jump_target c=%0d: got %b/%h/%h", c, bus.IF_valid, bus.IF_pc, bus.IF_instr);
                end
            end
        end
    endtask

    task automatic test_idrst();
        doReset();
        for (int c = 0; c < 23; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, (c == 17), 8'h00);
            if (c == 17) begin
                checks++;
                if ({bus.mem_addr, bus.mem_rd} !== {8'h10, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL idrst_cycle: got addr=%h rd=%b expected 10/0", bus.mem_addr, bus.mem_rd);
                end
            end else if (c == 18) begin
                checks++;
                if (bus.IF_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL idrst_flushed: got valid=%b expected 0", bus.IF_valid);
                end
            end else if (c == 19) begin
                checks++;
                if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'h00}) begin
                    errors++;
                    $display("[TB] FAIL idrst_issue: got rd=%b addr=%h expected 1/00", bus.mem_rd, bus.mem_addr);
                end
            end else if (c >= 21) begin
                checks++;
                if ({bus.IF_valid, bus.IF_pc, bus.IF_instr} !== ((c == 21) ? 25'h1_00_00FF : 25'h1_01_01FE)) begin
                    errors++;
                    $display("[TB] FAIL idrst_restart c=%0d: got %b/%h/%h", c, bus.IF_valid, bus.IF_pc, bus.IF_instr);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        doReset();
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b0, 1'b1, (c == 1), 1'b0, 8'hFE);
            if (c >= 5) begin
                e = 8'hFE + 8'(c - 5);
                checks++;
                if ({bus.IF_valid, bus.IF_pc, bus.IF_instr} !== {1'b1, e, e, ~e}) begin
                    errors++;
                    $display("[TB] FAIL wrap c=%0d: got %b/%h/%h expected 1/%h/%h",
                             c, bus.IF_valid, bus.IF_pc, bus.IF_instr, e, {e, ~e});
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        doReset();
        for (int c = 0; c < 9; c++) begin
            applyStimulus((c == 3), (c >= 4), 1'b0, 1'b0, 8'h00);
            if (c == 3) begin
                checks++;
                if (bus.IF_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL midrst_pre: got valid=%b expected 1", bus.IF_valid);
                end
            end else if (c == 4 || c == 6) begin
                checks++;
                if (bus.IF_valid !== 1'b0 || (c == 4 && bus.mem_rd !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL midrst_clear c=%0d: got v=%b rd=%b expected 0/0", c, bus.IF_valid, bus.mem_rd);
                end
            end else if (c == 5) begin
                checks++;
                if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 8'h00}) begin
                    errors++;
                    $display("[TB] FAIL midrst_issue: got rd=%b addr=%h expected 1/00", bus.mem_rd, bus.mem_addr);
                end
            end else if (c >= 7) begin
                checks++;
                if ({bus.IF_valid, bus.IF_pc, bus.IF_instr} !== ((c == 7) ? 25'h1_00_00FF : 25'h1_01_01FE)) begin
                    errors++;
                    $display("[TB] FAIL midrst_restart c=%0d: got %b/%h/%h", c, bus.IF_valid, bus.IF_pc, bus.IF_instr);
                end
            end
        end
    endtask

    // Program-order model: delivered addresses run consecutively from the
    // last jump target (or 0 after a local reset).
    task automatic test_random();
        logic [7:0] expNext = 8'h00;
        logic [7:0] prevPc = 8'h00;
        logic       prevStall = 1'b0;
        logic       prevFlush = 1'b0;
        logic       ready, skok, idrst;
        logic [7:0] tgt;
        int         r;
        int         transfers = 0;
        doReset();
        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            r     = $urandom_range(0, 29);
            skok  = (r == 0);
            idrst = (r == 1);
            tgt   = 8'($urandom);
            applyStimulus(1'b0, ready, skok, idrst, tgt);
            checks++;
            if (bus.mem_rd !== bus.pc_ink) begin
                errors++;
                $display("[TB] FAIL rand_rd_ink c=%0d: got rd=%b ink=%b expected equal", c, bus.mem_rd, bus.pc_ink);
            end
            if (prevFlush || skok || idrst) begin
                checks++;
                if (bus.mem_rd !== 1'b0 || (prevFlush && bus.IF_valid !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL rand_flush c=%0d: got rd=%b v=%b expected rd=0", c, bus.mem_rd, bus.IF_valid);
                end
            end
            if (prevStall) begin
                checks++;
                if ({bus.IF_valid, bus.IF_pc} !== {1'b1, prevPc}) begin
                    errors++;
                    $display("[TB] FAIL rand_stable c=%0d: got %b/%h expected 1/%h", c, bus.IF_valid, bus.IF_pc, prevPc);
                end
            end
            if (bus.IF_valid === 1'b1 && ready) begin
                checks++;
                if ({bus.IF_pc, bus.IF_instr} !== {expNext, expNext, ~expNext}) begin
                    errors++;
                    $display("[TB] FAIL rand_order c=%0d: got %h/%h expected %h/%h",
                             c, bus.IF_pc, bus.IF_instr, expNext, {expNext, ~expNext});
                end
                expNext = expNext + 8'h01;
                transfers++;
            end
            if (idrst)     expNext = 8'h00;
            else if (skok) expNext = tgt;
            prevStall = bus.IF_valid && !ready && !(skok || idrst);
            prevPc    = bus.IF_pc;
            prevFlush = skok || idrst;
        end
        checks++;
        if (transfers < 1000) begin
            errors++;
            $display("[TB] FAIL rand_progress: got %0d transfers expected at least 1000", transfers);
        end
    endtask

    initial begin
        bus.ID_ready = 1'b0;
        bus.skok_pc  = 1'b0;
        bus.ID_rst   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_idrst();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
